// File: rtl/data_down_sample_pkg.sv
// Shared constants for the tracking-engine downsampler and its consumers.
package data_down_sample_pkg;

  // Width and symmetric magnitude limit of the decimated I/Q samples.
  localparam int DOWN_OUT_WIDTH = 6;
  localparam int DOWN_OUT_MAX   = 31;

  // Accumulator width: input width plus enough headroom for 2^ratio_w samples.
  function automatic int acc_w(input int in_w, input int ratio_w);
    return in_w + ratio_w;
  endfunction

endpackage

// File: rtl/data_down_sample_if.sv
// Sample streams into and out of the decimator.
//
// Stream semantics: there is no back-pressure. A strobe (data_in_en /
// data_down_en) high for one clk cycle marks its data as valid on that cycle
// only. The receiver must take it then. shift_code travels with data_down_en.
interface data_down_sample_if
  import data_down_sample_pkg::*;
#(
  parameter int IN_WIDTH = 4
);
  logic                      data_in_en;
  logic [IN_WIDTH-1:0]       i_data_in;
  logic [IN_WIDTH-1:0]       q_data_in;
  logic                      data_down_en;
  logic [DOWN_OUT_WIDTH-1:0] i_data_down;
  logic [DOWN_OUT_WIDTH-1:0] q_data_down;
  logic                      shift_code;

  // Sample source and downstream consumer side.
  modport master (
    output data_in_en, i_data_in, q_data_in,
    input  data_down_en, i_data_down, q_data_down, shift_code
  );

  // Decimator side.
  modport slave (
    input  data_in_en, i_data_in, q_data_in,
    output data_down_en, i_data_down, q_data_down, shift_code
  );
endinterface

// File: rtl/data_down_sample_round_sat.sv
// One rail of the scale stage: round-half-up right shift of the dumped sum,
// then symmetric saturation to +/-DOWN_OUT_MAX. -32 is never produced
// because the consumer negates samples.
module data_down_sample_round_sat
  import data_down_sample_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0]          sum_in,
  input  logic [3:0]                shift,
  output logic [DOWN_OUT_WIDTH-1:0] dout,
  output logic                      clip
);

  // One extra bit keeps the rounding add from overflowing.
  localparam logic signed [ACC_W:0] ONE     = (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] POS_MAX = (ACC_W+1)'(DOWN_OUT_MAX);
  localparam logic signed [ACC_W:0] NEG_MAX = -POS_MAX;

  logic [3:0]              shift_eff;
  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   shifted;

  // Clamp shift, add half an LSB, arithmetic shift, then clip.
  always_comb begin
    shift_eff = shift;
    if (int'(shift) >= ACC_W) begin
      shift_eff = 4'(ACC_W - 1);
    end
    sum_ext = {sum_in[ACC_W-1], sum_in};
    rnd     = '0;
    if (shift_eff != 4'd0) begin
      rnd = ONE <<< (shift_eff - 4'd1);
    end
    shifted = (sum_ext + rnd) >>> shift_eff;
    dout    = shifted[DOWN_OUT_WIDTH-1:0];
    clip    = 1'b0;
    if (shifted > POS_MAX) begin
      dout = POS_MAX[DOWN_OUT_WIDTH-1:0];
      clip = 1'b1;
    end else if (shifted < NEG_MAX) begin
      dout = NEG_MAX[DOWN_OUT_WIDTH-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/data_down_sample.sv
// Integrate-and-dump I/Q decimator. Three registered stages:
//   accumulate/dump -> scale (round + saturate) -> output.
// An output appears two edges after the edge that accepts the (R+1)th input.
module data_down_sample
  import data_down_sample_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [RATIO_WIDTH-1:0] down_ratio,
  input  logic [3:0]             scale_shift,
  input  logic                   code_enable,
  input  logic                   clear_sat,
  data_down_sample_if.slave      bus,
  output logic                   sat_flag,
  output logic [15:0]            dump_count
);

  localparam int ACC_W = acc_w(IN_WIDTH, RATIO_WIDTH);

  // Accumulate stage
  logic [ACC_W-1:0]       i_acc_q, i_acc_d, q_acc_q, q_acc_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]       i_dump_q, i_dump_d, q_dump_q, q_dump_d;
  logic                   dump_vld_q, dump_vld_d;
  // Scale stage
  logic [DOWN_OUT_WIDTH-1:0] i_scl_q, i_scl_d, q_scl_q, q_scl_d;
  logic                      scl_vld_q, scl_vld_d;
  logic                      scl_clip_q, scl_clip_d;
  // Output stage
  logic [DOWN_OUT_WIDTH-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic                      out_en_q, out_en_d;
  logic                      shift_code_q, shift_code_d;
  logic                      sat_q, sat_d;
  logic [15:0]               dump_count_q, dump_count_d;

  logic [ACC_W-1:0]          i_samp, q_samp;
  logic [DOWN_OUT_WIDTH-1:0] i_rs, q_rs;
  logic                      i_clip, q_clip;

  assign i_samp = {{(ACC_W-IN_WIDTH){bus.i_data_in[IN_WIDTH-1]}}, bus.i_data_in};
  assign q_samp = {{(ACC_W-IN_WIDTH){bus.q_data_in[IN_WIDTH-1]}}, bus.q_data_in};

  // Accumulate accepted samples; dump once cnt reaches (or has passed) R.
  always_comb begin
    i_acc_d    = i_acc_q;
    q_acc_d    = q_acc_q;
    cnt_d      = cnt_q;
    i_dump_d   = i_dump_q;
    q_dump_d   = q_dump_q;
    dump_vld_d = 1'b0;
    if (!enable) begin
      i_acc_d = '0;
      q_acc_d = '0;
      cnt_d   = '0;
    end else if (bus.data_in_en) begin
      if (cnt_q >= down_ratio) begin
        i_dump_d   = i_acc_q + i_samp;
        q_dump_d   = q_acc_q + q_samp;
        dump_vld_d = 1'b1;
        i_acc_d    = '0;
        q_acc_d    = '0;
        cnt_d      = '0;
      end else begin
        i_acc_d = i_acc_q + i_samp;
        q_acc_d = q_acc_q + q_samp;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  data_down_sample_round_sat #(.ACC_W(ACC_W)) u_rs_i (
    .sum_in (i_dump_q),
    .shift  (scale_shift),
    .dout   (i_rs),
    .clip   (i_clip)
  );

  data_down_sample_round_sat #(.ACC_W(ACC_W)) u_rs_q (
    .sum_in (q_dump_q),
    .shift  (scale_shift),
    .dout   (q_rs),
    .clip   (q_clip)
  );

  // Scale stage: capture rounded/saturated rails one cycle after a dump.
  always_comb begin
    scl_vld_d  = dump_vld_q;
    i_scl_d    = i_scl_q;
    q_scl_d    = q_scl_q;
    scl_clip_d = 1'b0;
    if (dump_vld_q) begin
      i_scl_d    = i_rs;
      q_scl_d    = q_rs;
      scl_clip_d = i_clip | q_clip;
    end
  end

  // Output stage: strobe, held data, code strobe, sticky flag, dump counter.
  always_comb begin
    out_en_d     = scl_vld_q;
    shift_code_d = scl_vld_q & code_enable;
    i_out_d      = i_out_q;
    q_out_d      = q_out_q;
    sat_d        = sat_q;
    dump_count_d = dump_count_q;
    if (scl_vld_q) begin
      i_out_d      = i_scl_q;
      q_out_d      = q_scl_q;
      dump_count_d = dump_count_q + 16'd1;
    end
    if (clear_sat) begin
      sat_d = 1'b0;
    end
    // A new clip outranks a coincident clear.
    if (scl_vld_q && scl_clip_q) begin
      sat_d = 1'b1;
    end
  end

  // State registers for all three stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_acc_q      <= '0;
      q_acc_q      <= '0;
      cnt_q        <= '0;
      i_dump_q     <= '0;
      q_dump_q     <= '0;
      dump_vld_q   <= 1'b0;
      i_scl_q      <= '0;
      q_scl_q      <= '0;
      scl_vld_q    <= 1'b0;
      scl_clip_q   <= 1'b0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      out_en_q     <= 1'b0;
      shift_code_q <= 1'b0;
      sat_q        <= 1'b0;
      dump_count_q <= '0;
    end else begin
      i_acc_q      <= i_acc_d;
      q_acc_q      <= q_acc_d;
      cnt_q        <= cnt_d;
      i_dump_q     <= i_dump_d;
      q_dump_q     <= q_dump_d;
      dump_vld_q   <= dump_vld_d;
      i_scl_q      <= i_scl_d;
      q_scl_q      <= q_scl_d;
      scl_vld_q    <= scl_vld_d;
      scl_clip_q   <= scl_clip_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      out_en_q     <= out_en_d;
      shift_code_q <= shift_code_d;
      sat_q        <= sat_d;
      dump_count_q <= dump_count_d;
    end
  end

  assign bus.data_down_en = out_en_q;
  assign bus.i_data_down  = i_out_q;
  assign bus.q_data_down  = q_out_q;
  assign bus.shift_code   = shift_code_q;
  assign sat_flag         = sat_q;
  assign dump_count       = dump_count_q;

endmodule

// File: tb/tb_data_down_sample.sv
// Directed bench for the integrate-and-dump decimator.
module tb_data_down_sample;
  import data_down_sample_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  down_ratio;
  logic [3:0]  scale_shift;
  logic        code_enable;
  logic        clear_sat;
  logic        sat_flag;
  logic [15:0] dump_count;

  int tests      = 0;
  int fails      = 0;
  int exp_count  = 0;
  int gap [8]    = '{2, 0, 3, 1, 0, 4, 1, 2};

  data_down_sample_if #(.IN_WIDTH(4)) bus ();

  data_down_sample #(.IN_WIDTH(4), .RATIO_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .down_ratio  (down_ratio),
    .scale_shift (scale_shift),
    .code_enable (code_enable),
    .clear_sat   (clear_sat),
    .bus         (bus),
    .sat_flag    (sat_flag),
    .dump_count  (dump_count)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle input strobe.
  task automatic send(input logic [3:0] i, input logic [3:0] q);
    bus.data_in_en = 1'b1;
    bus.i_data_in  = i;
    bus.q_data_in  = q;
    step();
    bus.data_in_en = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'(bus.data_down_en), 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [5:0] ei, input logic [5:0] eq,
                            input logic esc);
    exp_count++;
    chk({tag, "_en"},  32'(bus.data_down_en), 32'd1);
    chk({tag, "_i"},   32'(bus.i_data_down),  32'(ei));
    chk({tag, "_q"},   32'(bus.q_data_down),  32'(eq));
    chk({tag, "_sc"},  32'(bus.shift_code),   32'(esc));
    chk({tag, "_cnt"}, 32'(dump_count),       32'(16'(exp_count)));
  endtask

  // Two inputs with R=1, then check the output two edges later.
  task automatic pair(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] qa, input logic [3:0] qb,
                      input logic [5:0] ei, input logic [5:0] eq);
    send(a, qa);
    send(b, qb);
    step();
    chk_quiet({tag, "_lat1"});
    step();
    expect_out(tag, ei, eq, 1'b1);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; down_ratio = '0; scale_shift = '0;
    code_enable = 1'b0; clear_sat = 1'b0;
    bus.data_in_en = 1'b0; bus.i_data_in = '0; bus.q_data_in = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_en",  32'(bus.data_down_en), 32'd0);
    chk("rst_i",   32'(bus.i_data_down),  32'd0);
    chk("rst_q",   32'(bus.q_data_down),  32'd0);
    chk("rst_sc",  32'(bus.shift_code),   32'd0);
    chk("rst_sat", 32'(sat_flag),         32'd0);
    chk("rst_cnt", 32'(dump_count),       32'd0);

    // Gain and timing: R=3, I=+2, Q=-1 every cycle -> +8/-4 every 4th input.
    enable = 1'b1; code_enable = 1'b1; down_ratio = 8'd3; scale_shift = 4'd0;
    for (int c = 0; c < 14; c++) begin
      bus.data_in_en = (c < 12);
      bus.i_data_in  = 4'd2;
      bus.q_data_in  = 4'hF;
      step();
      if (c == 5 || c == 9 || c == 13) expect_out("gain", 6'd8, 6'h3C, 1'b1);
      else chk_quiet("gain_idle");
    end
    bus.data_in_en = 1'b0;
    step();
    chk("hold_i", 32'(bus.i_data_down), 32'd8);
    chk("hold_q", 32'(bus.q_data_down), 32'h3C);

    // Saturation: 16 x (+7,-8) -> +31/-31, sticky flag, set beats clear.
    down_ratio = 8'd15;
    for (int k = 0; k < 16; k++) send(4'd7, 4'h8);
    step();
    chk_quiet("sat_lat1");
    step();
    expect_out("sat", 6'h1F, 6'h21, 1'b1);
    chk("sat_set", 32'(sat_flag), 32'd1);
    repeat (3) step();
    chk("sat_sticky", 32'(sat_flag), 32'd1);
    clear_sat = 1'b1;
    step();
    clear_sat = 1'b0;
    chk("sat_clear", 32'(sat_flag), 32'd0);
    for (int k = 0; k < 16; k++) send(4'd7, 4'h8);
    step();
    clear_sat = 1'b1;
    step();
    clear_sat = 1'b0;
    expect_out("sat2", 6'h1F, 6'h21, 1'b1);
    chk("sat_set_wins", 32'(sat_flag), 32'd1);
    clear_sat = 1'b1;
    step();
    clear_sat = 1'b0;
    chk("sat_clear2", 32'(sat_flag), 32'd0);

    // Rounding: R=1, shift=2, round-half-up.
    down_ratio = 8'd1; scale_shift = 4'd2;
    pair("rnd_a", 4'd3, 4'd2, 4'hD, 4'hE, 6'h01, 6'h3F);
    pair("rnd_b", 4'hD, 4'hE, 4'd3, 4'd2, 6'h3F, 6'h01);
    pair("rnd_c", 4'd1, 4'd0, 4'hF, 4'h0, 6'h00, 6'h00);
    pair("rnd_d", 4'd1, 4'd1, 4'hF, 4'hF, 6'h01, 6'h00);

    // Shift clamp: 256 x (+7,-8) = 1792/-2048, shift 15 acts as 11.
    down_ratio = 8'd255; scale_shift = 4'd15;
    for (int k = 0; k < 256; k++) send(4'd7, 4'h8);
    step();
    chk_quiet("clamp_lat1");
    step();
    expect_out("clamp", 6'h01, 6'h3F, 1'b1);

    // R=0 back-to-back: one output per cycle.
    down_ratio = 8'd0; scale_shift = 4'd0;
    for (int c = 0; c < 5; c++) begin
      bus.data_in_en = (c < 3);
      bus.i_data_in  = 4'(c + 1);
      bus.q_data_in  = 4'd0;
      step();
      if (c >= 2) expect_out("b2b", 6'(c - 1), 6'd0, 1'b1);
      else chk_quiet("b2b_idle");
    end
    bus.data_in_en = 1'b0;

    // Irregular gaps, R=7, code_enable=0.
    down_ratio = 8'd7; code_enable = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        step();
        chk_quiet("gap_idle");
      end
      send(4'd1, 4'hF);
      if (k < 7) chk_quiet("gap_in");
    end
    step();
    chk_quiet("gap_lat1");
    step();
    expect_out("gap", 6'd8, 6'h38, 1'b0);
    code_enable = 1'b1;

    // Enable drop clears the partial sum; inputs while disabled are ignored.
    down_ratio = 8'd3;
    send(4'd1, 4'd1);
    send(4'd1, 4'd1);
    enable = 1'b0;
    bus.data_in_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk_quiet("dis_idle");
    end
    bus.data_in_en = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(4'd1, 4'd1);
      chk_quiet("reen_in");
    end
    send(4'd1, 4'd1);
    step();
    chk_quiet("reen_lat1");
    step();
    expect_out("reen", 6'd4, 6'd4, 1'b1);

    // Ratio lowered below cnt: dump on the next input.
    down_ratio = 8'd7;
    for (int k = 0; k < 5; k++) begin
      send(4'd1, 4'd0);
      chk_quiet("ratio_in");
    end
    down_ratio = 8'd2;
    send(4'd1, 4'd0);
    step();
    chk_quiet("ratio_lat1");
    step();
    expect_out("ratio", 6'd6, 6'd0, 1'b1);

    // Reset with a dump in flight.
    down_ratio = 8'd1;
    send(4'd3, 4'd0);
    send(4'd3, 4'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_count = 0;
    chk("mrst_en",  32'(bus.data_down_en), 32'd0);
    chk("mrst_i",   32'(bus.i_data_down),  32'd0);
    chk("mrst_q",   32'(bus.q_data_down),  32'd0);
    chk("mrst_sc",  32'(bus.shift_code),   32'd0);
    chk("mrst_sat", 32'(sat_flag),         32'd0);
    chk("mrst_cnt", 32'(dump_count),       32'd0);
    step();
    chk_quiet("mrst_q1");
    step();
    chk_quiet("mrst_q2");
    send(4'd3, 4'd0);
    step();
    chk_quiet("mrst_p1");
    step();
    chk_quiet("mrst_p2");
    send(4'd3, 4'd0);
    step();
    chk_quiet("mrst_lat1");
    step();
    expect_out("mrst", 6'd6, 6'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
